// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (m0) and the EXU
//   load/store handler (m1). Requests are arbitrated round-robin, and a grant
//   is locked while its downstream request is stalled. A 1-bit ID FIFO
//   remembers who issued each in-flight transaction, so that in-order
//   responses can be routed back to the right requester.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   m0_req_slv_*      fetch request in     (vld/rdy, addr, st, data, strobe)
//   m0_rsp_mst_*      fetch response out   (vld/rdy, data)
//   m1_req_slv_*      ldst request in
//   m1_rsp_mst_*      ldst response out
//   s_req_mst_*       downstream request out
//   s_rsp_slv_*       downstream response in (strictly in request order)
//   busy              high while any transaction is outstanding
module mem_port_arbiter #(
  parameter int unsigned OSTD_DEPTH = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_req_slv_vld,
  output logic            m0_req_slv_rdy,
  input  logic [AW-1:0]   m0_req_slv_addr,
  input  logic            m0_req_slv_st,
  input  logic [DW-1:0]   m0_req_slv_data,
  input  logic [DW/8-1:0] m0_req_slv_strobe,
  output logic            m0_rsp_mst_vld,
  input  logic            m0_rsp_mst_rdy,
  output logic [DW-1:0]   m0_rsp_mst_data,

  input  logic            m1_req_slv_vld,
  output logic            m1_req_slv_rdy,
  input  logic [AW-1:0]   m1_req_slv_addr,
  input  logic            m1_req_slv_st,
  input  logic [DW-1:0]   m1_req_slv_data,
  input  logic [DW/8-1:0] m1_req_slv_strobe,
  output logic            m1_rsp_mst_vld,
  input  logic            m1_rsp_mst_rdy,
  output logic [DW-1:0]   m1_rsp_mst_data,

  output logic            s_req_mst_vld,
  input  logic            s_req_mst_rdy,
  output logic [AW-1:0]   s_req_mst_addr,
  output logic            s_req_mst_st,
  output logic [DW-1:0]   s_req_mst_data,
  output logic [DW/8-1:0] s_req_mst_strobe,

  input  logic            s_rsp_slv_vld,
  output logic            s_rsp_slv_rdy,
  input  logic [DW-1:0]   s_rsp_slv_data,

  output logic            busy
);

  localparam int unsigned PW = $clog2(OSTD_DEPTH);
  localparam int unsigned CW = $clog2(OSTD_DEPTH + 1);

  logic [CW-1:0] ostd_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          id_fifo [OSTD_DEPTH];
  logic          rr_last;
  logic          lock_vld;
  logic          lock_id;

  logic          full;
  logic          empty;
  logic          win_vld;
  logic          win_id;
  logic          head;
  logic          push;
  logic          pop;

  assign full  = (ostd_cnt == CW'(OSTD_DEPTH));
  assign empty = (ostd_cnt == '0);
  assign busy  = ~empty;

  // A locked grant overrides arbitration until its request is accepted.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (lock_vld) begin
      win_vld = 1'b1;
      win_id  = lock_id;
    end else if (m0_req_slv_vld && m1_req_slv_vld) begin
      win_vld = 1'b1;
      win_id  = ~rr_last;
    end else if (m0_req_slv_vld) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (m1_req_slv_vld) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
  end

  // Request path: rdy depends only on registered count, never on the response side.
  assign s_req_mst_vld    = win_vld & ~full;
  assign s_req_mst_addr   = win_id ? m1_req_slv_addr   : m0_req_slv_addr;
  assign s_req_mst_st     = win_id ? m1_req_slv_st     : m0_req_slv_st;
  assign s_req_mst_data   = win_id ? m1_req_slv_data   : m0_req_slv_data;
  assign s_req_mst_strobe = win_id ? m1_req_slv_strobe : m0_req_slv_strobe;
  assign m0_req_slv_rdy   = s_req_mst_rdy & ~full & win_vld & ~win_id;
  assign m1_req_slv_rdy   = s_req_mst_rdy & ~full & win_vld &  win_id;
  assign push             = s_req_mst_vld & s_req_mst_rdy;

  // Response path: the FIFO head names the requester that owns the response.
  assign head            = id_fifo[rd_ptr];
  assign m0_rsp_mst_vld  = s_rsp_slv_vld & ~empty & ~head;
  assign m1_rsp_mst_vld  = s_rsp_slv_vld & ~empty &  head;
  assign m0_rsp_mst_data = s_rsp_slv_data;
  assign m1_rsp_mst_data = s_rsp_slv_data;
  assign s_rsp_slv_rdy   = ~empty & (head ? m1_rsp_mst_rdy : m0_rsp_mst_rdy);
  assign pop             = s_rsp_slv_vld & s_rsp_slv_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ostd_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr_last  <= 1'b1;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        rr_last  <= win_id;
        lock_vld <= 1'b0;
      end else if (s_req_mst_vld) begin
        lock_vld <= 1'b1;
        lock_id  <= win_id;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   ostd_cnt <= ostd_cnt + CW'(1);
        2'b01:   ostd_cnt <= ostd_cnt - CW'(1);
        default: ostd_cnt <= ostd_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        m0_req_slv_vld, m0_req_slv_rdy, m0_req_slv_st;
  logic [31:0] m0_req_slv_addr, m0_req_slv_data;
  logic [3:0]  m0_req_slv_strobe;
  logic        m0_rsp_mst_vld, m0_rsp_mst_rdy;
  logic [31:0] m0_rsp_mst_data;
  logic        m1_req_slv_vld, m1_req_slv_rdy, m1_req_slv_st;
  logic [31:0] m1_req_slv_addr, m1_req_slv_data;
  logic [3:0]  m1_req_slv_strobe;
  logic        m1_rsp_mst_vld, m1_rsp_mst_rdy;
  logic [31:0] m1_rsp_mst_data;
  logic        s_req_mst_vld, s_req_mst_rdy, s_req_mst_st;
  logic [31:0] s_req_mst_addr, s_req_mst_data;
  logic [3:0]  s_req_mst_strobe;
  logic        s_rsp_slv_vld, s_rsp_slv_rdy;
  logic [31:0] s_rsp_slv_data;
  logic        busy;

  mem_port_arbiter #(.OSTD_DEPTH(D), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_slv_vld(m0_req_slv_vld), .m0_req_slv_rdy(m0_req_slv_rdy),
    .m0_req_slv_addr(m0_req_slv_addr), .m0_req_slv_st(m0_req_slv_st),
    .m0_req_slv_data(m0_req_slv_data), .m0_req_slv_strobe(m0_req_slv_strobe),
    .m0_rsp_mst_vld(m0_rsp_mst_vld), .m0_rsp_mst_rdy(m0_rsp_mst_rdy),
    .m0_rsp_mst_data(m0_rsp_mst_data),
    .m1_req_slv_vld(m1_req_slv_vld), .m1_req_slv_rdy(m1_req_slv_rdy),
    .m1_req_slv_addr(m1_req_slv_addr), .m1_req_slv_st(m1_req_slv_st),
    .m1_req_slv_data(m1_req_slv_data), .m1_req_slv_strobe(m1_req_slv_strobe),
    .m1_rsp_mst_vld(m1_rsp_mst_vld), .m1_rsp_mst_rdy(m1_rsp_mst_rdy),
    .m1_rsp_mst_data(m1_rsp_mst_data),
    .s_req_mst_vld(s_req_mst_vld), .s_req_mst_rdy(s_req_mst_rdy),
    .s_req_mst_addr(s_req_mst_addr), .s_req_mst_st(s_req_mst_st),
    .s_req_mst_data(s_req_mst_data), .s_req_mst_strobe(s_req_mst_strobe),
    .s_rsp_slv_vld(s_rsp_slv_vld), .s_rsp_slv_rdy(s_rsp_slv_rdy),
    .s_rsp_slv_data(s_rsp_slv_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester and downstream environment
  bit          r_act [2];
  logic [31:0] r_addr[2];
  logic [31:0] r_data[2];
  logic        r_st  [2];
  logic [3:0]  r_strb[2];
  bit          rsp_act;
  logic [31:0] rsp_data;
  int          ds_pend;
  bit          force_both;
  int p_req, p_srdy, p_rsp, p_mrdy;

  // Reference model: queue of owners of accepted-but-unanswered transactions,
  // the requester whose offered request is still pending, and the last grantee.
  int owners[$];
  int pend;
  int last_grant;

  task automatic drive();
    m0_req_slv_vld    = r_act[0];
    m0_req_slv_addr   = r_addr[0];
    m0_req_slv_data   = r_data[0];
    m0_req_slv_st     = r_st[0];
    m0_req_slv_strobe = r_strb[0];
    m1_req_slv_vld    = r_act[1];
    m1_req_slv_addr   = r_addr[1];
    m1_req_slv_data   = r_data[1];
    m1_req_slv_st     = r_st[1];
    m1_req_slv_strobe = r_strb[1];
    s_rsp_slv_vld     = rsp_act;
    s_rsp_slv_data    = rsp_data;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      r_act[i] = 0; r_addr[i] = '0; r_data[i] = '0; r_st[i] = 1'b0; r_strb[i] = '0;
    end
    rsp_act = 0; rsp_data = '0; ds_pend = 0;
    s_req_mst_rdy = 1'b0; m0_rsp_mst_rdy = 1'b0; m1_rsp_mst_rdy = 1'b0;
    owners.delete(); pend = -1; last_grant = 1;
    drive();
  endtask

  task automatic evaluate();
    int  w;
    bit  full, ev, ne, exp_srr;
    int  head;
    w = -1;
    if (pend >= 0)                w = pend;
    else if (r_act[0] && r_act[1]) w = 1 - last_grant;
    else if (r_act[0])            w = 0;
    else if (r_act[1])            w = 1;
    full = (owners.size() == D);
    ev   = (w >= 0) && !full;
    check("s_req_vld", s_req_mst_vld, ev);
    if (ev) begin
      check("s_req_addr", s_req_mst_addr, r_addr[w]);
      check("s_req_data", s_req_mst_data, r_data[w]);
      check("s_req_st_strb", {s_req_mst_st, s_req_mst_strobe}, {r_st[w], r_strb[w]});
    end
    check("m0_req_rdy", m0_req_slv_rdy, ev && w == 0 && s_req_mst_rdy);
    check("m1_req_rdy", m1_req_slv_rdy, ev && w == 1 && s_req_mst_rdy);

    ne   = (owners.size() != 0);
    head = ne ? owners[0] : 0;
    check("m0_rsp_vld", m0_rsp_mst_vld, s_rsp_slv_vld && ne && head == 0);
    check("m1_rsp_vld", m1_rsp_mst_vld, s_rsp_slv_vld && ne && head == 1);
    check("m0_rsp_data", m0_rsp_mst_data, s_rsp_slv_data);
    check("m1_rsp_data", m1_rsp_mst_data, s_rsp_slv_data);
    exp_srr = ne && (head == 0 ? m0_rsp_mst_rdy : m1_rsp_mst_rdy);
    check("s_rsp_rdy", s_rsp_slv_rdy, exp_srr);
    check("busy", busy, ne);

    // model state after the coming clock edge
    if (s_rsp_slv_vld && exp_srr) void'(owners.pop_front());
    if (ev && s_req_mst_rdy) begin
      owners.push_back(w);
      last_grant = w;
      pend = -1;
    end else if (ev) begin
      pend = w;
    end

    // environment bookkeeping from what the bus actually did
    for (int i = 0; i < 2; i++)
      if (r_act[i] && ((i == 0) ? m0_req_slv_rdy : m1_req_slv_rdy)) r_act[i] = 0;
    if (s_req_mst_vld && s_req_mst_rdy) ds_pend++;
    if (rsp_act && s_rsp_slv_rdy) begin
      rsp_act = 0;
      ds_pend--;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!r_act[i] && (force_both || $urandom_range(99) < p_req)) begin
        r_act[i]  = 1;
        r_addr[i] = $urandom;
        r_data[i] = $urandom;
        r_st[i]   = 1'($urandom_range(1));
        r_strb[i] = 4'($urandom_range(15));
      end
    end
    force_both = 0;
    s_req_mst_rdy = ($urandom_range(99) < p_srdy);
    if (!rsp_act && ds_pend > 0 && $urandom_range(99) < p_rsp) begin
      rsp_act  = 1;
      rsp_data = $urandom;
    end
    m0_rsp_mst_rdy = ($urandom_range(99) < p_mrdy);
    m1_rsp_mst_rdy = ($urandom_range(99) < p_mrdy);
    drive();
    #1 evaluate();
  endtask

  task automatic run(input int n, input int pr, input int ps, input int pp, input int pm);
    p_req = pr; p_srdy = ps; p_rsp = pp; p_mrdy = pm;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_s_rsp_rdy", s_rsp_slv_rdy, 1'b0);
    check("rst_m0_rsp_vld", m0_rsp_mst_vld, 1'b0);
    check("rst_m1_rsp_vld", m1_rsp_mst_vld, 1'b0);
    clear_all();
    #1 check("rst_s_req_vld", s_req_mst_vld, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    force_both = 0;
    clear_all();
    #3;
    check("init_busy", busy, 1'b0);
    check("init_s_req_vld", s_req_mst_vld, 1'b0);
    check("init_s_rsp_rdy", s_rsp_slv_rdy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // first contention after reset goes to m0
    force_both = 1;
    run(1, 0, 100, 0, 100);
    check("first_grant_m0", m0_req_slv_rdy, 1'b1);

    run(400, 50, 70, 60, 80);   // mixed traffic
    run(300, 100, 90, 15, 70);  // heavy contention, slow memory: reaches full
    run(300, 60, 20, 50, 60);   // downstream stalls exercise the grant lock
    run(200, 30, 100, 90, 100); // streaming

    // reset with transactions in flight
    run(30, 100, 100, 5, 50);
    mid_reset();
    force_both = 1;
    run(1, 0, 100, 0, 100);
    check("post_rst_grant_m0", m0_req_slv_rdy, 1'b1);
    run(300, 70, 60, 40, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single core memory port between the instruction-fetch requester (m0) and the EXU load/store handler (m1). It sits between the IFU/EXU and the memory/bus bridge. It arbitrates `ldst_req_if_t` requests round-robin with grant lock, and tracks up to `OSTD_DEPTH` in-flight transactions in an ID FIFO. It routes each in-order `ldst_rsp_if_t` response back to the requester that issued it.

## Interface
- `OSTD_DEPTH`, default 4: maximum outstanding downstream transactions. Power of two, ≥2.
- `clk`  in  1  core clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  async active-low reset.
- `m0_req_slv`  ldst_req_if_t.slv  —  requester 0 (fetch) request: vld/rdy, pkt{addr,st,data,strobe}.
- `m0_rsp_mst`  ldst_rsp_if_t.mst  —  requester 0 response: vld/rdy, pkt{data}.
- `m1_req_slv`  ldst_req_if_t.slv  —  requester 1 (EXU ldst) request.
- `m1_rsp_mst`  ldst_rsp_if_t.mst  —  requester 1 response.
- `s_req_mst`  ldst_req_if_t.mst  —  downstream memory request.
- `s_rsp_slv`  ldst_rsp_if_t.slv  —  downstream memory response. Responses return strictly in request order.
- `busy`  out  1  high while any transaction is outstanding (count ≠ 0).

## Operation
- State:
  - `ostd_cnt` is a 0..OSTD_DEPTH counter.
  - The ID FIFO holds OSTD_DEPTH entries of 1 bit each, with wr/rd pointers of log2(OSTD_DEPTH) bits that wrap naturally.
  - `rr_last` (1 bit) is the last granted requester.
  - `lock_vld` / `lock_id` hold the grant across a stalled request.
- `full` = (ostd_cnt == OSTD_DEPTH); `empty` = (ostd_cnt == 0).
- Winner selection, combinational:
  - If `lock_vld`, the winner is `lock_id`.
  - Else if exactly one mN_req_slv.vld is high, that requester wins.
  - Else if both are high, the winner is `~rr_last`.
  - Else there is no winner.
- Downstream request:
  - s_req_mst.vld = winner exists & ~full.
  - s_req_mst.pkt = winner's pkt (mux).
- Request ready: the winner's req rdy = s_req_mst.rdy & ~full. The loser's rdy = 0.
- Request handshake (s_req_mst.vld & s_req_mst.rdy) does the following:
  - push the winner id into the FIFO;
  - ostd_cnt += 1;
  - rr_last ← winner;
  - lock_vld ← 0.
- Stall: if s_req_mst.vld & ~s_req_mst.rdy, then lock_vld ← 1 and lock_id ← winner. The grant must not switch while a downstream request is pending.
- Response routing (head = FIFO[rd_ptr]):
  - mH_rsp_mst.vld = s_rsp_slv.vld & ~empty & (head == H).
  - The other requester's rsp vld = 0.
  - Both rsp pkt.data = s_rsp_slv.pkt.data (broadcast).
  - s_rsp_slv.rdy = ~empty & m{head}_rsp_mst.rdy.
- Response handshake pops the FIFO and decrements ostd_cnt.
- Push and pop in the same cycle: ostd_cnt is unchanged, and both pointers advance.
- Full: no push, even if a pop occurs in the same cycle. Request rdy is computed from the registered count only, so there is no combinational path from rsp to req.
- Empty: s_rsp_slv.rdy = 0, and a downstream response is not consumed. Such a response is a protocol violation; the bench flags it.
- Lock while full: lock_vld stays set. The locked requester is granted as soon as `full` deasserts.

## Timing
- Request path and response path are both zero-cycle combinational pass-through. There is no added latency.
- Registered state updates on the posedge clk following a handshake.
- Reset (async, rst_n low) clears all of the following immediately:
  - ostd_cnt = 0 and pointers = 0;
  - rr_last = 1, so m0 wins the first contention;
  - lock_vld = 0 and lock_id = 0;
  - busy = 0.
- Outputs during reset:
  - s_req_mst.vld follows inputs but is gated to 0 by reset-time state only if no requester is valid.
  - Requester rsp vld = 0 (FIFO empty).
  - s_rsp_slv.rdy = 0.
- Reset mid-operation: all outstanding IDs are discarded. The downstream side must be reset concurrently.
- Throughput: one request per cycle and one response per cycle, simultaneously.
- Back-to-back requests from the same requester are accepted every cycle while the other requester is idle.

## Test plan
- Single m1 load:
  - Stimulus: m1 vld, addr=0x100, st=0; downstream rdy=1; response data=0xDEADBEEF two cycles later.
  - Required: s_req_mst.pkt.addr=0x100; busy=1 for 2 cycles; m1_rsp vld with 0xDEADBEEF; m0_rsp vld stays 0; busy returns to 0.
- Contention:
  - Stimulus: m0 and m1 both held vld for 4 cycles; rdy=1.
  - Required: grants are m0, m1, m0, m1; FIFO ids are 0,1,0,1; in-order responses are delivered to m0, m1, m0, m1.
- Grant lock:
  - Stimulus: m1 vld alone; s_req_mst.rdy=0 for 3 cycles; m0 asserts vld in cycle 1.
  - Required: pkt stays m1's and m0 rdy=0 until m1's handshake in cycle 3; m0 is granted in cycle 4.
- Full:
  - Stimulus: OSTD_DEPTH=4; 4 requests accepted, no responses.
  - Required: ostd_cnt=4; s_req_mst.vld=0 and both req rdy=0 on the 5th. After one response, the 5th request is accepted the next cycle.
- Simultaneous push/pop and response backpressure:
  - Stimulus: cnt=2, req and rsp handshake in the same cycle; then m0_rsp rdy=0 with head=0.
  - Required: cnt stays 2; s_rsp_slv.rdy=0 until m0 rdy=1.
- Async reset:
  - Stimulus: rst_n low with 3 outstanding.
  - Required: busy=0, s_rsp_slv.rdy=0 immediately. After release, the first contention grants m0.
